// File: rtl/gs_row_buffer_pkg.sv
// Shared constants and types for the grayscale row store and the TLC5941 pixel driver.
// Row layout: blue fields from bit 0, green from 192, red from 384; bit 0 is shifted first.
package gs_row_buffer_pkg;

  localparam int PIXELS     = 16;
  localparam int GS_BITS    = 12;
  localparam int ROW_BITS   = 3 * PIXELS * GS_BITS;
  localparam int BLUE_BASE  = 0;
  localparam int GREEN_BASE = PIXELS * GS_BITS;
  localparam int RED_BASE   = 2 * PIXELS * GS_BITS;
  localparam int BIT_IDX_W  = 10;
  localparam int PIX_IDX_W  = $clog2(PIXELS);
  localparam int PIX_W      = 3 * GS_BITS;

  typedef struct packed {
    logic [GS_BITS-1:0] r;
    logic [GS_BITS-1:0] g;
    logic [GS_BITS-1:0] b;
  } pix_t;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } bank_state_t;

endpackage

// File: rtl/gs_row_bank.sv
// One 576-bit row register with a pixel write port scattering r/g/b into their colour planes.
// Write lands one cycle after wr_en; clear has priority over a write in the same cycle.
module gs_row_bank
  import gs_row_buffer_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 wr_en,
  input  logic [PIX_IDX_W-1:0] wr_idx,
  input  pix_t                 wr_dat,
  output logic [ROW_BITS-1:0]  row
);

  int field_ofs;

  assign field_ofs = GS_BITS * int'(wr_idx);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      row <= '0;
    end else if (clear) begin
      row <= '0;
    end else if (wr_en) begin
      row[BLUE_BASE  + field_ofs +: GS_BITS] <= wr_dat.b;
      row[GREEN_BASE + field_ofs +: GS_BITS] <= wr_dat.g;
      row[RED_BASE   + field_ofs +: GS_BITS] <= wr_dat.r;
    end
  end

endmodule

// File: rtl/gs_row_buffer.sv
// Double-buffered grayscale row store: fills a back bank from a pixel stream, swaps on xlat.
// One pixel per clock while filling; pix_ready is registered state and drops once a row is complete.
module gs_row_buffer
  import gs_row_buffer_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  input  logic [PIX_W-1:0]     pix_data,
  input  logic                 pix_last,
  input  logic [BIT_IDX_W-1:0] bit_index,
  output logic                 gs_bit,
  input  logic                 row_swap,
  output logic                 row_ready,
  output logic [7:0]           row_count,
  output logic [7:0]           underrun_count,
  output logic                 sync_err
);

  localparam logic [PIX_IDX_W-1:0] LAST_IDX = PIX_IDX_W'(PIXELS - 1);

  bank_state_t           state, nxt_state;
  logic [PIX_IDX_W-1:0]  pix_count;
  logic [ROW_BITS-1:0]   back, front;
  logic                  xfer, row_done, swap_ok, underrun, bank_clr;

  assign xfer     = pix_valid && pix_ready;
  assign row_done = xfer && (pix_last || (pix_count == LAST_IDX));
  assign swap_ok  = row_swap && (state == ST_FULL);
  assign underrun = row_swap && (state == ST_FILL);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_FILL;
    else          state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    bank_clr  = 1'b0;
    pix_ready = 1'b0;
    row_ready = 1'b0;
    case (state)
      ST_FILL: begin
        pix_ready = 1'b1;
        if (row_done) nxt_state = ST_FULL;
      end
      ST_FULL: begin
        row_ready = 1'b1;
        if (row_swap) begin
          nxt_state = ST_FILL;
          bank_clr  = 1'b1;
        end
      end
      default: nxt_state = ST_FILL;
    endcase
  end

  gs_row_bank u_back (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (bank_clr),
    .wr_en   (xfer),
    .wr_idx  (pix_count),
    .wr_dat  (pix_t'(pix_data)),
    .row     (back)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      front          <= '0;
      pix_count      <= '0;
      row_count      <= '0;
      underrun_count <= '0;
      sync_err       <= 1'b0;
    end else begin
      if (swap_ok) begin
        front     <= back;
        pix_count <= '0;
        row_count <= row_count + 8'd1;
      end else if (xfer) begin
        pix_count <= pix_count + 1'b1;
      end
      if (underrun && (underrun_count != 8'hFF))
        underrun_count <= underrun_count + 8'd1;
      // Row boundary and pix_last must coincide; any disagreement is latched until reset.
      if (xfer && (pix_last != (pix_count == LAST_IDX)))
        sync_err <= 1'b1;
    end
  end

  assign gs_bit = (int'(bit_index) < ROW_BITS) ? front[bit_index] : 1'b0;

endmodule
